eq_gain_loader: RTL
===================

// Module: eq_gain_loader
// PURPOSE
//  Writer side of the equalizer gain bus. Accepts 8-word gain frames over a valid/ready stream
//  and collects them in a shadow bank. Commits the whole frame atomically to the active gain
//  bank g[7:0] on a sample strobe, so the filter/gain path never sees a mixed set of gains.
//  Sits between the control/host interface and the 8-band equalizer gain inputs.
// PARAMETERS
//  NUM_BANDS  8        number of gain words per frame; the equalizer fixes this at 8
//  GAIN_W     16       gain word width, unsigned Q4.12
//  GAIN_RST   16'h1000 reset/unity value of every active and shadow gain (1.0 in Q4.12)
//  RAMP_STEP  16'h0040 per-strobe slew step; used only with EQ_GAIN_RAMP_EN
// PORTS
//  clk          in   1                  clock
//  rst_n        in   1                  asynchronous reset, active low
//  cfg_valid    in   1                  gain word valid
//  cfg_ready    out  1                  loader can accept a word
//  cfg_first    in   1                  qualifies the word as band 0 of a new frame
//  cfg_data     in   GAIN_W             gain word, bands sent in order 0..7
//  sample_tick  in   1                  one-cycle strobe per audio sample (commit point)
//  g            out  GAIN_W x NUM_BANDS active gains to the equalizer, g[k] for band k
//  gain_updated out  1                  one-cycle pulse when the active bank changes to the final target
//  frame_err    out  1                  one-cycle pulse when a frame is malformed
//  busy         out  1                  a frame is being loaded, pending, or ramping
// BEHAVIOUR
//  - Reset (async): state IDLE; idx=0; every g[k] and shadow[k] = GAIN_RST. cfg_ready=1;
//    gain_updated, frame_err and busy are all 0.
//  - Transfer: a word is accepted when cfg_valid && cfg_ready on a rising clk edge.
//  - FSM states:
//    IDLE: on transfer with cfg_first: shadow[0]=cfg_data, idx=1, go to LOAD.
//      On transfer without cfg_first: drop the word, pulse frame_err, stay in IDLE.
//    LOAD: on transfer without cfg_first: shadow[idx]=cfg_data, idx++.
//      On transfer with cfg_first: restart the frame (shadow[0]=data, idx=1) and pulse frame_err.
//      Accepting word idx=NUM_BANDS-1 moves to PEND.
//    PEND: cfg_ready=0. On sample_tick: g[k]=shadow[k] for all k at once, pulse gain_updated
//      the following cycle, go to IDLE.
//  - sample_tick in the same cycle as the last word: no commit yet; the commit happens on the
//    next sample_tick after PEND is entered. sample_tick in IDLE or LOAD is ignored.
//  - busy = (state != IDLE). g is registered and changes only on a committing clk edge.
//  - Latency: last word accepted -> PEND next cycle -> g updates on the edge at the first
//    following sample_tick.
//  - Reset mid-frame or mid-ramp: the partial frame is discarded and all gains return to
//    GAIN_RST.
//  - No arithmetic other than idx (clog2(NUM_BANDS) bits, never wraps past NUM_BANDS-1) and
//    the ramp logic below.
// CONFIGURATION
//  EQ_GAIN_RAMP_EN defined: adds state RAMP. From PEND, sample_tick enters RAMP instead of a
//    direct copy. On each sample_tick in RAMP, every g[k] moves toward shadow[k] by
//    min(RAMP_STEP, |shadow[k]-g[k]|), using unsigned compare with no overflow.
//    When all g[k]==shadow[k], pulse gain_updated and go to IDLE. cfg_ready=0 in RAMP.
//  EQ_GAIN_RAMP_EN undefined: no RAMP state; commit is the one-step copy above.
//    RAMP_STEP is unused.
// STRUCTURE
//  Package eq_pkg: NUM_BANDS, GAIN_W, GAIN_UNITY (16'h1000), typedef gain_t
//    (logic [GAIN_W-1:0]), typedef gain_bank_t (gain_t [NUM_BANDS-1:0]), enum
//    loader_state_e {IDLE, LOAD, PEND, RAMP}.
//  Sub-module: gain_slew, one instance per band, generated only under EQ_GAIN_RAMP_EN.
//    Inputs: current, target, step, tick. Outputs: next value and done flag.
// TESTING
//  1. Reset, then no stimulus: all g[k]==16'h1000; cfg_ready=1; busy=0; no pulses.
//  2. Send frame 16'h0800,16'h1000,...,16'h2000 with cfg_first on word 0, then one sample_tick:
//     g is unchanged before the tick, equals the frame after it; gain_updated pulses exactly once.
//  3. Send 3 words, then a new cfg_first word followed by a full frame: one frame_err pulse;
//     the committed g is the second frame only.
//  4. Word without cfg_first while IDLE: dropped, frame_err pulses, g unchanged.
//  5. Assert rst_n low while in PEND: g==16'h1000 immediately (async); a later sample_tick
//     commits nothing.
//  6. With EQ_GAIN_RAMP_EN, g[0] goes 16'h1000 -> 16'h1100, step 16'h0040: reaches the target
//     after 4 ticks; gain_updated pulses once, at the end of the ramp.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and sizing for the equalizer gain loader.
package eq_pkg;

  localparam int unsigned NUM_BANDS = 8;
  localparam int unsigned GAIN_W    = 16;
  localparam int unsigned IDX_W     = $clog2(NUM_BANDS);

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h1000;
  localparam logic [GAIN_W-1:0] GAIN_RST   = GAIN_UNITY;
  localparam logic [GAIN_W-1:0] RAMP_STEP  = 16'h0040;

  typedef logic [GAIN_W-1:0]        gain_t;
  typedef gain_t [NUM_BANDS-1:0]    gain_bank_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2,
    RAMP = 2'd3
  } loader_state_e;

endpackage

// File: rtl/gain_slew.sv
// One band of the gain ramp: steps current toward target by at most step per tick.
module gain_slew
  import eq_pkg::*;
(
  input  logic [GAIN_W-1:0] current_i,
  input  logic [GAIN_W-1:0] target_i,
  input  logic [GAIN_W-1:0] step_i,
  input  logic              tick_i,
  output logic [GAIN_W-1:0] next_c,
  output logic              done_c
);

  logic              up_c;
  logic [GAIN_W-1:0] diff_c;
  logic [GAIN_W-1:0] delta_c;

  // Delta is clamped to the remaining distance, so the move can never overshoot or wrap.
  always_comb begin
    up_c    = (target_i > current_i);
    diff_c  = up_c ? GAIN_W'(target_i - current_i) : GAIN_W'(current_i - target_i);
    delta_c = (diff_c < step_i) ? diff_c : step_i;
    next_c  = current_i;
    if (tick_i) begin
      next_c = up_c ? GAIN_W'(current_i + delta_c) : GAIN_W'(current_i - delta_c);
    end
    done_c  = (next_c == target_i);
  end

endmodule

// File: rtl/eq_gain_loader.sv
// Equalizer gain loader: collects 8-word frames into a shadow bank, commits atomically on sample_tick.
// Optional EQ_GAIN_RAMP_EN: commit slews each gain toward its target by RAMP_STEP per tick.
module eq_gain_loader
  import eq_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic                              cfg_first,
  input  logic [GAIN_W-1:0]                 cfg_data,
  input  logic                              sample_tick,
  output logic [NUM_BANDS-1:0][GAIN_W-1:0]  g,
  output logic                              gain_updated,
  output logic                              frame_err,
  output logic                              busy
);

  loader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  gain_bank_t        shadow_q, shadow_d;
  gain_bank_t        g_q, g_d;
  logic              gain_updated_q, gain_updated_d;
  logic              frame_err_q, frame_err_d;
  logic              cfg_ready_q;
  logic              busy_q;
  logic              xfer_c;

  assign xfer_c = cfg_valid && cfg_ready_q;

`ifdef EQ_GAIN_RAMP_EN
  gain_bank_t            slew_next_c;
  logic [NUM_BANDS-1:0]  slew_done_c;

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_slew
    gain_slew u_slew (
      .current_i (g_q[k]),
      .target_i  (shadow_q[k]),
      .step_i    (RAMP_STEP),
      .tick_i    (sample_tick),
      .next_c    (slew_next_c[k]),
      .done_c    (slew_done_c[k])
    );
  end
`endif

  // Next-state, shadow fill and commit logic.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    shadow_d       = shadow_q;
    g_d            = g_q;
    gain_updated_d = 1'b0;
    frame_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          if (cfg_first) begin
            shadow_d[0] = cfg_data;
            idx_d       = IDX_W'(1);
            state_d     = LOAD;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer_c) begin
          if (cfg_first) begin
            shadow_d[0] = cfg_data;
            idx_d       = IDX_W'(1);
            frame_err_d = 1'b1;
          end else begin
            shadow_d[idx_q] = cfg_data;
            if (idx_q == IDX_W'(NUM_BANDS - 1)) begin
              idx_d   = '0;
              state_d = PEND;
            end else begin
              idx_d = IDX_W'(idx_q + IDX_W'(1));
            end
          end
        end
      end
      PEND: begin
        if (sample_tick) begin
`ifdef EQ_GAIN_RAMP_EN
          state_d = RAMP;
`else
          g_d            = shadow_q;
          gain_updated_d = 1'b1;
          state_d        = IDLE;
`endif
        end
      end
`ifdef EQ_GAIN_RAMP_EN
      RAMP: begin
        if (sample_tick) begin
          g_d = slew_next_c;
          if (&slew_done_c) begin
            gain_updated_d = 1'b1;
            state_d        = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ready and busy are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      shadow_q       <= {NUM_BANDS{GAIN_RST}};
      g_q            <= {NUM_BANDS{GAIN_RST}};
      gain_updated_q <= 1'b0;
      frame_err_q    <= 1'b0;
      cfg_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
      g_q            <= g_d;
      gain_updated_q <= gain_updated_d;
      frame_err_q    <= frame_err_d;
      cfg_ready_q    <= (state_d == IDLE) || (state_d == LOAD);
      busy_q         <= (state_d != IDLE);
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign g            = g_q;
  assign gain_updated = gain_updated_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;

endmodule
